// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types and constants for the UART transmit scheduler
package uart_tx_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [7:0] HDR_BASE     = 8'hA0;
  localparam logic [7:0] HDR_IDX_MASK = 8'h07;

  // Header byte announcing which requester owns the following data bytes.
  function automatic logic [7:0] hdr_byte(input int idx);
    return HDR_BASE | (8'(idx) & HDR_IDX_MASK);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
  parameter int  NREQ = 2,
  localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pending,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic            any
);

  int              idx;
  logic [NREQ-1:0] cand;

  // Walk last+1, last+2, ... (wrapping) and take the first pending requester.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = NREQ'(1) << idx;
      if (!any && ((pending & cand) != '0)) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares the UART TX FIFO among word sources; UART_TX_SCHED_HEADER_EN adds a header byte
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DBIT       = 8,
  parameter int WORD_BYTES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*WORD_BYTES*DBIT-1:0] data,
  input  logic                            fifo_full,
  output logic                            fifo_wr,
  output logic [DBIT-1:0]                 fifo_din,
  output logic [NREQ-1:0]                 grant,
  output logic                            busy,
  output logic [NREQ-1:0]                 done
);

  localparam int WW = WORD_BYTES * DBIT;
`ifdef UART_TX_SCHED_HEADER_EN
  localparam int NB = WORD_BYTES + 1;
`else
  localparam int NB = WORD_BYTES;
`endif
  localparam int SW = NB * DBIT;
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(NB + 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [LW-1:0]   last_q, last_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;

  logic [NREQ-1:0] req_edge;
  logic [NREQ-1:0] winner;
  logic            any;
  logic [LW-1:0]   win_idx;
  logic [WW-1:0]   win_word;
  logic [SW-1:0]   load_val;
  logic            take;
  logic            last_byte;

  assign req_edge = req & ~req_q;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .pending(pending_q),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  // Turn the one-hot winner into an index and pick out its word.
  always_comb begin
    win_idx  = '0;
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        win_idx  = LW'(i);
        win_word = data[i*WW +: WW];
      end
    end
  end

`ifdef UART_TX_SCHED_HEADER_EN
  assign load_val = {DBIT'(hdr_byte(int'(win_idx))), win_word};
`else
  assign load_val = win_word;
`endif

  assign take      = (state_q == ST_IDLE) && any;
  assign last_byte = fifo_wr && (cnt_q == CW'(NB - 1));
  assign fifo_din  = shift_q[SW-1 -: DBIT];
  assign grant     = grant_q;
  assign done      = done_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave IDLE on any pending request, return after the final byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any)       state_d = ST_SEND;
      ST_SEND: if (last_byte) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: write whenever sending and the FIFO has room.
  always_comb begin
    busy    = (state_q == ST_SEND);
    fifo_wr = (state_q == ST_SEND) && !fifo_full;
  end

  // Datapath next values; a new edge wins over the grant-time clear so it is never lost.
  always_comb begin
    pending_d = (pending_q & ~(take ? winner : '0)) | req_edge;
    last_d    = last_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    if (take) begin
      last_d  = win_idx;
      grant_d = winner;
      cnt_d   = '0;
      shift_d = load_val;
    end else if (fifo_wr) begin
      shift_d = shift_q << DBIT;
      cnt_d   = cnt_q + CW'(1);
      if (last_byte) begin
        grant_d = '0;
        done_d  = NREQ'(1) << last_q;
      end
    end
  end

  // Datapath registers; last resets to NREQ-1 so requester 0 is served first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= '0;
      pending_q <= '0;
      last_q    <= LW'(NREQ - 1);
      shift_q   <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler against a queue-based model
module tb_uart_tx_scheduler;

  localparam int NREQ = 2;
  localparam int DBIT = 8;
  localparam int WB   = 2;
`ifdef UART_TX_SCHED_HEADER_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic                     clk       = 1'b0;
  logic                     reset     = 1'b0;
  logic [NREQ-1:0]          req       = '0;
  logic [NREQ*WB*DBIT-1:0]  data      = '0;
  logic                     fifo_full = 1'b0;
  logic                     fifo_wr;
  logic [DBIT-1:0]          fifo_din;
  logic [NREQ-1:0]          grant;
  logic                     busy;
  logic [NREQ-1:0]          done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]      wlog[$];
  int              wcyc[$];
  logic [NREQ-1:0] dlog[$];
  int              dcyc[$];

  // Model: pending set, round-robin pointer, and the bytes still owed by the current transfer.
  logic [NREQ-1:0] m_pend  = '0;
  logic [NREQ-1:0] m_prev  = '0;
  logic [NREQ-1:0] m_done  = '0;
  logic [NREQ-1:0] m_edges = '0;
  int              m_last  = NREQ - 1;
  int              m_owner = 0;
  logic [7:0]      mq[$];

  uart_tx_scheduler #(
    .NREQ(NREQ),
    .DBIT(DBIT),
    .WORD_BYTES(WB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .fifo_full(fifo_full),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din),
    .grant    (grant),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    int         idx;
    logic [15:0] w;
    logic       found;
    if (reset) begin
      m_pend  = '0;
      m_prev  = '0;
      m_done  = '0;
      m_last  = NREQ - 1;
      m_owner = 0;
      mq.delete();
    end else begin
      m_edges = req & ~m_prev;
      m_prev  = req;
      m_done  = '0;
      if (mq.size() == 0) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (!found && (((m_pend >> idx) & NREQ'(1)) != '0)) begin
            found   = 1'b1;
            m_owner = idx;
            m_last  = idx;
            m_pend  = m_pend & ~(NREQ'(1) << idx);
            w       = 16'(data >> (idx * 16));
            if (HB != 0) mq.push_back(8'hA0 | 8'(idx));
            mq.push_back(w[15:8]);
            mq.push_back(w[7:0]);
          end
        end
      end else if (!fifo_full) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = NREQ'(1) << m_owner;
      end
      m_pend = m_pend | m_edges;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic compare();
    logic eb;
    eb = (mq.size() != 0);
    chk("busy", 32'(busy), 32'(eb));
    chk("fifo_wr", 32'(fifo_wr), 32'(eb && !fifo_full));
    if (eb && !fifo_full) chk("fifo_din", 32'(fifo_din), 32'(mq[0]));
    chk("grant", 32'(grant), 32'(eb ? (NREQ'(1) << m_owner) : '0));
    chk("done", 32'(done), 32'(m_done));
    if (fifo_wr) begin
      wlog.push_back(fifo_din);
      wcyc.push_back(cyc);
    end
    if (done != '0) begin
      dlog.push_back(done);
      dcyc.push_back(cyc);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    dlog.delete();
    dcyc.delete();
  endtask

  task automatic chk_bytes(input string nm, input logic [7:0] e[$]);
    chk({nm, "_len"}, wlog.size(), e.size());
    for (int i = 0; i < e.size() && i < wlog.size(); i++) chk(nm, 32'(wlog[i]), 32'(e[i]));
  endtask

  initial begin
    logic [7:0] e[$];
    int         p;

    #1 reset = 1'b1;
    #1;
    chk("rst_fifo_wr", 32'(fifo_wr), 0);
    chk("rst_fifo_din", 32'(fifo_din), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run(2);

    // Single request on requester 0.
    clear_logs();
    data = {16'h0000, 16'h1234};
    req  = 2'b01;
    p    = cyc;
    run(8);
    e = {};
    if (HB != 0) e.push_back(8'hA0);
    e.push_back(8'h12);
    e.push_back(8'h34);
    chk_bytes("t1_bytes", e);
    chk("t1_first_lat", (wcyc.size() > 0) ? wcyc[0] - p : -1, 2);
    chk("t1_done_n", dlog.size(), 1);
    if (dlog.size() > 0) chk("t1_done_who", 32'(dlog[0]), 1);
    if (dcyc.size() > 0) chk("t1_done_lat", dcyc[0] - p, 4 + HB);
    clear_logs();
    run(8);
    chk("t1_hold_norepeat", wlog.size(), 0);

    // Requester 1 alone (also leaves last = 1).
    clear_logs();
    data = {16'hBEEF, 16'h0000};
    req  = 2'b10;
    p    = cyc;
    run(8);
    e = {};
    if (HB != 0) e.push_back(8'hA1);
    e.push_back(8'hBE);
    e.push_back(8'hEF);
    chk_bytes("t6_bytes", e);
    chk("t6_done_n", dlog.size(), 1);
    if (dlog.size() > 0) chk("t6_done_who", 32'(dlog[0]), 2);
    if (dcyc.size() > 0) chk("t6_done_lat", dcyc[0] - p, 4 + HB);

    // Simultaneous requests, twice.
    req = 2'b00;
    run(2);
    clear_logs();
    data = {16'h5555, 16'hAAAA};
    req  = 2'b11;
    run(12);
    e = {};
    if (HB != 0) e.push_back(8'hA0);
    e.push_back(8'hAA);
    e.push_back(8'hAA);
    if (HB != 0) e.push_back(8'hA1);
    e.push_back(8'h55);
    e.push_back(8'h55);
    chk_bytes("t2_pair1", e);
    req = 2'b00;
    run(2);
    clear_logs();
    req = 2'b11;
    run(12);
    chk_bytes("t2_pair2", e);
    chk("t2_done_n", dlog.size(), 2);
    if (dlog.size() > 0) chk("t2_done_first", 32'(dlog[0]), 1);

    // Back-pressure for 5 cycles after grant.
    req = 2'b00;
    run(2);
    clear_logs();
    data = {16'h0000, 16'h0F1E};
    req  = 2'b01;
    p    = cyc;
    run(2);
    fifo_full = 1'b1;
    run(5);
    fifo_full = 1'b0;
    run(8);
    e = {};
    if (HB != 0) e.push_back(8'hA0);
    e.push_back(8'h0F);
    e.push_back(8'h1E);
    chk_bytes("t3_bytes", e);
    chk("t3_first_lat", (wcyc.size() > 0) ? wcyc[0] - p : -1, 7);
    chk("t3_done_lat", (dcyc.size() > 0) ? dcyc[0] - p : -1, 9 + HB);

    // Re-request during own transfer; the third edge merges.
    req = 2'b00;
    run(2);
    clear_logs();
    data = {16'h7788, 16'h0000};
    req  = 2'b10;
    run(2);
    fifo_full = 1'b1;
    req = 2'b00; run(2);
    req = 2'b10; run(2);
    req = 2'b00; run(2);
    req = 2'b10; run(2);
    fifo_full = 1'b0;
    run(20);
    chk("t4_bytes_n", wlog.size(), 2 * (2 + HB));
    if (wlog.size() > HB) chk("t4_first_data", 32'(wlog[HB]), 32'h77);
    chk("t4_done_n", dlog.size(), 2);
    if (dlog.size() > 1) chk("t4_done_who", 32'(dlog[1]), 2);

    // Reset after the high byte, req held through release.
    req = 2'b00;
    run(2);
    clear_logs();
    data = {16'h0000, 16'hC35A};
    req  = 2'b01;
    run(3 + HB);
    chk("t5_pre_bytes", wlog.size(), 1 + HB);
    reset = 1'b1;
    #1;
    chk("t5_rst_fifo_wr", 32'(fifo_wr), 0);
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    run(2);
    reset = 1'b0;
    clear_logs();
    run(8);
    e = {};
    if (HB != 0) e.push_back(8'hA0);
    e.push_back(8'hC3);
    e.push_back(8'h5A);
    chk_bytes("t5_fresh", e);
    chk("t5_done_n", dlog.size(), 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ (NREQ'(1) << $urandom_range(0, NREQ - 1));
      data      = $urandom;
      fifo_full = ($urandom_range(0, 9) < 3);
      cycle();
    end
    req       = '0;
    fifo_full = 1'b0;
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequences and shares the UART transmit FIFO among several 16-bit word sources, such as the accumulator dump and debug/status words. Each requester raises a level request, and the block captures one transfer per rising edge. Requesters are granted round-robin. Each granted word is split into bytes, high byte first, and pushed into the transmit FIFO with full-flag back-pressure. The block sits between the datapath's word sources and the FIFO that feeds the transmitter.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `DBIT`, 8: FIFO byte width.
- `WORD_BYTES`, 2: bytes per requester word.

- `clk`, in, 1: system clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, NREQ: level request per requester. Only a rising edge is significant.
- `data`, in, NREQ*WORD_BYTES*DBIT: flattened words. Requester i occupies `[i*WORD_BYTES*DBIT +: WORD_BYTES*DBIT]`.
- `fifo_full`, in, 1: transmit FIFO full.
- `fifo_wr`, out, 1: one-cycle FIFO write strobe.
- `fifo_din`, out, DBIT: byte being written.
- `grant`, out, NREQ: one-hot, held for the whole transfer.
- `busy`, out, 1: high while in SEND.
- `done`, out, NREQ: one-cycle pulse on the owning requester after its last byte is written.

## Operation
- **Edge capture**
  - `req_q` registers `req`.
  - `edge[i] = req[i] & ~req_q[i]`.
  - An edge sets `pending[i]`.
  - An edge on a requester that is already pending is merged (no second transfer).
  - An edge on the requester currently being served sets `pending` again, which queues a new transfer.
- **State machine**
  - **IDLE**: if any `pending` bit is set, select the winner round-robin. The search starts at `last+1` mod NREQ. On the same edge:
    - clear `pending[winner]`
    - set `grant`
    - latch the winner's word into the shift register
    - set `last` to the winner and `byte_cnt` to 0
    - go to SEND.
  - **SEND**
    - `fifo_wr = !fifo_full`, combinational.
    - `fifo_din` = top byte of the shift register.
    - On each write: shift left by DBIT, increment `byte_cnt`.
    - On the write of the final byte: pulse `done[winner]`, clear `grant`, go to IDLE.
- **Data capture**: `data` is sampled only at grant. Later changes do not affect the transfer in flight.
- **Back-pressure**: `fifo_full` stalls SEND indefinitely. No byte is dropped or duplicated.
- **Reset values**: all outputs are 0. State is IDLE, `pending` = 0, `req_q` = 0, `last` = NREQ-1, so requester 0 wins first.
- **Reset release**: a `req` held high through reset release counts as one edge.
- **Reset mid-transfer**: the partial word is abandoned and the FIFO is left holding whatever bytes were already written.

## Timing
- **Request to first byte**, assuming `fifo_full` = 0:
  - edge N samples `req` = 1 with `req_q` = 0; `pending` is set.
  - edge N+1 produces the grant and latches the word.
  - the high byte is written at edge N+2.
  - the low byte is written at edge N+3.
  - `done` is high for the cycle after N+3.
- **Stall**: each cycle with `fifo_full` = 1 adds exactly one cycle.
- **Inter-word gap**: one IDLE cycle between consecutive transfers.
- **Throughput**: with WORD_BYTES = 2 and no header, the minimum transfer is 3 cycles per word.
- **Pending is lossless**: a requester whose edge arrives while another is served is granted no later than after NREQ-1 intervening transfers.

## Configuration
- Macro: `UART_TX_SCHED_HEADER_EN`.
- **Defined**
  - Each transfer is prefixed by one header byte: `8'hA0 | index`, with the index in the low 3 bits.
  - The header is written before the data bytes, so a transfer is WORD_BYTES+1 bytes.
  - `done` is delayed by one byte.
  - Minimum cost is 4 cycles per word.
- **Undefined**: bytes are data only; timing is as in the Timing section.

## Structure
- Package `uart_tx_sched_pkg`:
  - state encoding IDLE/SEND
  - header base constant `8'hA0`
  - header index mask.
- Sub-module `rr_arbiter`:
  - parameter NREQ
  - inputs: `pending`, `last`
  - outputs: one-hot `winner`, `any`
  - purely combinational.
- All sequencing lives in `uart_tx_scheduler`.

## Test plan
1. **Single request**: NREQ = 2, `data[15:0]` = 16'h1234, `req[0]` rises.
   - `fifo_wr` writes 8'h12 at N+2 and 8'h34 at N+3.
   - `done[0]` pulses once.
   - Holding `req` high afterwards causes no repeat.
2. **Simultaneous requests**: `req` = 2'b11 in the same cycle, words 16'hAAAA and 16'h5555.
   - Output byte order is AA, AA, 55, 55.
   - A second simultaneous pair yields requester 0 first again, because `last` = 1 after the first pair.
3. **Back-pressure**: `fifo_full` held 1 for 5 cycles after grant.
   - No `fifo_wr` while full.
   - Bytes arrive in order once full drops.
   - `done` is delayed by exactly 5 cycles.
4. **Re-request during own transfer**: `req[1]` toggles 0→1→0→1 while requester 1 is in SEND.
   - A second full transfer of requester 1 follows.
   - A third edge arriving while pending is still set is merged.
5. **Reset mid-transfer**: assert `reset` after the high byte is written.
   - `fifo_wr`, `grant`, `busy` and `done` go to 0 immediately.
   - After release with `req` held high, one fresh transfer of both bytes occurs.
6. **Header build** (`UART_TX_SCHED_HEADER_EN` defined): `req[1]` with 16'hBEEF.
   - Output is A1, BE, EF.
   - `done[1]` pulses after EF.
